// File: rtl/regfile_wr_arbiter_pkg.sv
// Shared definitions for the register-file write arbiter: FSM encoding,
// parameter defaults and an index-width helper.
package regfile_wr_arbiter_pkg;

    // ARB: requesters compete for the write port.
    // CLEAR: the block walks every register and writes zero.
    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_e;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_REQ  = 3;

    // Width of an index into n items; never less than 1 bit so that
    // single-item configurations still elaborate.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/regfile_wr_arbiter_rr_grant.sv
// Round-robin grant: picks the first asserted request at or after ptr,
// wrapping around. Output is one-hot, or zero when nothing is requested.
module rr_grant
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int N = DEF_NUM_REQ,
    localparam int PTR_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N-1:0]     gnt
);

    logic found;

    // Scan requesters in rotation order starting at ptr; first hit wins.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (j == ((int'(ptr) + k) % N))) begin
                    gnt[j] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/regfile_wr_arbiter.sv
// Register-file write-port arbiter. Several writeback requesters share one
// write port under round-robin arbitration; a clear command takes the port
// for NUM_REGS cycles and zeroes every register in ascending order.
//
// Handshake: a requester transfers in the cycle where req_valid[i] and
// req_ready[i] are both 1. req_ready is combinational from req_valid, the
// priority pointer, the FSM state, clr_start and rst; it never looks at a
// requester's own ready, so valid may depend on nothing but the requester.
// The accepted write appears on rf_wr_en/rf_wr_data one cycle later.
module regfile_wr_arbiter
    import regfile_wr_arbiter_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_REQ  = DEF_NUM_REQ,
    localparam int ADDR_W  = idx_w(NUM_REGS),
    localparam int PTR_W   = idx_w(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      clr_start,
    output logic                      clr_busy,
    output logic [NUM_REGS-1:0]       rf_wr_en,
    output logic [DATA_W-1:0]         rf_wr_data
);

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    ptr_q, ptr_d;
    logic [ADDR_W-1:0]   clr_idx_q, clr_idx_d;
    logic [NUM_REGS-1:0] wr_en_q, wr_en_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0]  gnt;
    logic                grant_ok;
    logic [ADDR_W-1:0]   sel_addr;
    logic [DATA_W-1:0]   sel_data;
    logic [NUM_REGS-1:0] clr_en;

    rr_grant #(
        .N (NUM_REQ)
    ) u_rr_grant (
        .req (req_valid),
        .ptr (ptr_q),
        .gnt (gnt)
    );

    // State register and write-port pipeline flops; reset clears everything.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_ARB;
            ptr_q     <= '0;
            clr_idx_q <= '0;
            wr_en_q   <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            clr_idx_q <= clr_idx_d;
            wr_en_q   <= wr_en_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next state: clr_start preempts arbitration; CLEAR runs NUM_REGS cycles.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        clr_idx_d = clr_idx_q;
        case (state_q)
            ST_ARB: begin
                if (clr_start) begin
                    state_d   = ST_CLEAR;
                    clr_idx_d = '0;
                end else begin
                    for (int i = 0; i < NUM_REQ; i++) begin
                        if (req_ready[i]) begin
                            ptr_d = (i == NUM_REQ - 1) ? '0 : PTR_W'(i + 1);
                        end
                    end
                end
            end
            ST_CLEAR: begin
                if (int'(clr_idx_q) == NUM_REGS - 1) begin
                    state_d   = ST_ARB;
                    clr_idx_d = '0;
                end else begin
                    clr_idx_d = clr_idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d   = ST_ARB;
                clr_idx_d = '0;
            end
        endcase
    end

    // Outputs: ready gating, granted-write capture, and the clear walk.
    always_comb begin
        grant_ok  = (state_q == ST_ARB) && !clr_start && !rst;
        req_ready = grant_ok ? gnt : '0;

        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_ready[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end

        // Out-of-range indices match no register, so the write is dropped.
        wr_en_d   = '0;
        wr_data_d = '0;
        if (|req_ready) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                wr_en_d[r] = (int'(sel_addr) == r);
            end
            wr_data_d = sel_data;
        end

        clr_en = '0;
        for (int r = 0; r < NUM_REGS; r++) begin
            clr_en[r] = (state_q == ST_CLEAR) && (int'(clr_idx_q) == r);
        end

        clr_busy   = (state_q == ST_CLEAR);
        rf_wr_en   = (state_q == ST_CLEAR) ? clr_en : wr_en_q;
        rf_wr_data = (state_q == ST_CLEAR) ? '0 : wr_data_q;
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Bench for regfile_wr_arbiter: reset checks, a hand-computed vector table,
// multi-cycle clear/reset sequences, randomized traffic against a reference
// model, and an out-of-range address check on a 6-register instance.
module tb_regfile_wr_arbiter;

    localparam int DW  = 16;
    localparam int NR  = 8;
    localparam int NQ  = 3;
    localparam int AW  = 3;
    localparam int NR6 = 6;
    localparam int QW  = 1 + NR + DW;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [NQ-1:0]    req_valid, req_ready;
    logic [NQ*AW-1:0] req_addr;
    logic [NQ*DW-1:0] req_data;
    logic             clr_start, clr_busy;
    logic [NR-1:0]    rf_wr_en;
    logic [DW-1:0]    rf_wr_data;

    logic [NQ-1:0]    req_valid6, req_ready6;
    logic [NQ*AW-1:0] req_addr6;
    logic [NQ*DW-1:0] req_data6;
    logic             clr_start6, clr_busy6;
    logic [NR6-1:0]   rf_wr_en6;
    logic [DW-1:0]    rf_wr_data6;

    regfile_wr_arbiter u_dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_data   (req_data),
        .req_ready  (req_ready),
        .clr_start  (clr_start),
        .clr_busy   (clr_busy),
        .rf_wr_en   (rf_wr_en),
        .rf_wr_data (rf_wr_data)
    );

    regfile_wr_arbiter #(.NUM_REGS(NR6)) u_dut6 (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid6),
        .req_addr   (req_addr6),
        .req_data   (req_data6),
        .req_ready  (req_ready6),
        .clr_start  (clr_start6),
        .clr_busy   (clr_busy6),
        .rf_wr_en   (rf_wr_en6),
        .rf_wr_data (rf_wr_data6)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int m_busy_rem;            // clear writes still to appear, including current
    int m_ptr;                 // requester with highest priority next
    logic [QW-1:0] exp_q[$];   // expected {clr_busy, rf_wr_en, rf_wr_data} per cycle

    function automatic int model_grant();
        if (m_busy_rem > 0 || clr_start) return -1;
        for (int k = 0; k < NQ; k++) begin
            if (req_valid[(m_ptr + k) % NQ]) return (m_ptr + k) % NQ;
        end
        return -1;
    endfunction

    task automatic model_update(input int g);
        logic [QW-1:0] e;
        int a;
        e = '0;
        if (m_busy_rem > 0) begin
            m_busy_rem--;
            if (m_busy_rem > 0) begin
                e[QW-1]    = 1'b1;
                e[DW +: NR] = NR'(1) << (NR - m_busy_rem);
            end
        end else if (clr_start) begin
            m_busy_rem  = NR;
            e[QW-1]     = 1'b1;
            e[DW +: NR] = NR'(1);
        end else if (g >= 0) begin
            a = int'(req_addr[g*AW +: AW]);
            if (a < NR) e[DW +: NR] = NR'(1) << a;
            e[DW-1:0] = req_data[g*DW +: DW];
            m_ptr = (g + 1) % NQ;
        end
        exp_q.push_back(e);
    endtask

    // ---------------- drivers ----------------
    task automatic drive(input logic [2:0] v, input logic [2:0] a0, input logic [2:0] a1,
                         input logic [2:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                         input logic [15:0] d2, input logic clr);
        req_valid = v;
        req_addr  = {a2, a1, a0};
        req_data  = {d2, d1, d0};
        clr_start = clr;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(3'b111, 3'd1, 3'd2, 3'd3, 16'h1, 16'h2, 16'h3, 1'b0);
        @(negedge clk);
        check("rst_ready", req_ready, 3'b000);
        check("rst_wr_en", rf_wr_en, 8'h00);
        check("rst_wr_data", rf_wr_data, 16'h0000);
        check("rst_busy", clr_busy, 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);
        m_busy_rem = 0;
        m_ptr      = 0;
        exp_q.delete();
        exp_q.push_back('0);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [2:0]  v;
        logic [2:0]  a0, a1, a2;
        logic [15:0] d0, d1, d2;
        logic [2:0]  rdy;
        logic [7:0]  en;
        logic [15:0] data;
        bit          chk;
    } vec_t;

    function automatic vec_t mk(input logic [2:0] v, input logic [2:0] a0, input logic [2:0] a1,
                                input logic [2:0] a2, input logic [15:0] d0, input logic [15:0] d1,
                                input logic [15:0] d2, input logic [2:0] rdy, input logic [7:0] en,
                                input logic [15:0] data, input bit chk);
        vec_t r;
        r.v = v; r.a0 = a0; r.a1 = a1; r.a2 = a2;
        r.d0 = d0; r.d1 = d1; r.d2 = d2;
        r.rdy = rdy; r.en = en; r.data = data; r.chk = chk;
        return r;
    endfunction

    vec_t tbl[13];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [QW-1:0] e;
        int g;

        req_valid6 = '0; req_addr6 = '0; req_data6 = '0; clr_start6 = 1'b0;

        // Each row: inputs this cycle, expected ready this cycle, and the
        // expected write port contents this cycle (from the previous row).
        tbl[0]  = mk(3'b001, 3'd3, 3'd0, 3'd0, 16'hBEEF, 16'h0, 16'h0, 3'b001, 8'h00, 16'h0000, 1'b1);
        tbl[1]  = mk(3'b100, 3'd0, 3'd0, 3'd5, 16'h0, 16'h0, 16'h5555, 3'b100, 8'h08, 16'hBEEF, 1'b1);
        tbl[2]  = mk(3'b101, 3'd1, 3'd0, 3'd5, 16'h1111, 16'h0, 16'h5555, 3'b001, 8'h20, 16'h5555, 1'b1);
        tbl[3]  = mk(3'b010, 3'd0, 3'd2, 3'd0, 16'h0, 16'h2222, 16'h0, 3'b010, 8'h02, 16'h1111, 1'b1);
        tbl[4]  = mk(3'b100, 3'd0, 3'd0, 3'd4, 16'h0, 16'h0, 16'h4444, 3'b100, 8'h04, 16'h2222, 1'b1);
        tbl[5]  = mk(3'b111, 3'd0, 3'd6, 3'd7, 16'hA000, 16'hA001, 16'hA002, 3'b001, 8'h10, 16'h4444, 1'b1);
        tbl[6]  = mk(3'b111, 3'd0, 3'd6, 3'd7, 16'hA000, 16'hA001, 16'hA002, 3'b010, 8'h01, 16'hA000, 1'b1);
        tbl[7]  = mk(3'b111, 3'd0, 3'd6, 3'd7, 16'hA000, 16'hA001, 16'hA002, 3'b100, 8'h40, 16'hA001, 1'b1);
        tbl[8]  = mk(3'b111, 3'd0, 3'd6, 3'd7, 16'hA000, 16'hA001, 16'hA002, 3'b001, 8'h80, 16'hA002, 1'b1);
        tbl[9]  = mk(3'b111, 3'd0, 3'd6, 3'd7, 16'hA000, 16'hA001, 16'hA002, 3'b010, 8'h01, 16'hA000, 1'b1);
        tbl[10] = mk(3'b111, 3'd0, 3'd6, 3'd7, 16'hA000, 16'hA001, 16'hA002, 3'b100, 8'h40, 16'hA001, 1'b1);
        tbl[11] = mk(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 3'b000, 8'h80, 16'hA002, 1'b1);
        tbl[12] = mk(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 3'b000, 8'h00, 16'h0000, 1'b0);

        do_reset();

        for (int n = 0; n < 13; n++) begin
            drive(tbl[n].v, tbl[n].a0, tbl[n].a1, tbl[n].a2, tbl[n].d0, tbl[n].d1, tbl[n].d2, 1'b0);
            @(negedge clk);
            check($sformatf("tbl%0d_ready", n), req_ready, tbl[n].rdy);
            check($sformatf("tbl%0d_wr_en", n), rf_wr_en, tbl[n].en);
            if (tbl[n].chk) check($sformatf("tbl%0d_wr_data", n), rf_wr_data, tbl[n].data);
            @(posedge clk);
            #1;
        end

        // clr_start with req1 valid: clear wins, second pulse mid-clear ignored.
        drive(3'b010, 3'd0, 3'd2, 3'd0, 16'h0, 16'h7777, 16'h0, 1'b1);
        @(negedge clk);
        check("clr_prio_ready", req_ready, 3'b000);
        @(posedge clk);
        #1;
        for (int k = 0; k < NR; k++) begin
            clr_start = (k == 3);
            @(negedge clk);
            check($sformatf("clr%0d_wr_en", k), rf_wr_en, NR'(1) << k);
            check($sformatf("clr%0d_wr_data", k), rf_wr_data, 16'h0000);
            check($sformatf("clr%0d_busy", k), clr_busy, 1'b1);
            check($sformatf("clr%0d_ready", k), req_ready, 3'b000);
            @(posedge clk);
            #1;
        end
        clr_start = 1'b0;
        @(negedge clk);
        check("clr_done_busy", clr_busy, 1'b0);
        check("clr_done_wr_en", rf_wr_en, 8'h00);
        check("clr_done_ready", req_ready, 3'b010);
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        @(negedge clk);
        check("post_clr_wr_en", rf_wr_en, 8'h04);
        check("post_clr_wr_data", rf_wr_data, 16'h7777);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("post_clr_idle_wr_en", rf_wr_en, 8'h00);
        check("post_clr_idle_busy", clr_busy, 1'b0);
        @(posedge clk);
        #1;

        // Reset at the 4th clear write aborts the sequence for good.
        clr_start = 1'b1;
        @(posedge clk);
        #1;
        drive(3'b111, 3'd0, 3'd1, 3'd2, 16'hC000, 16'hC001, 16'hC002, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("abort%0d_wr_en", k), rf_wr_en, NR'(1) << k);
            if (k < 3) begin
                @(posedge clk);
                #1;
            end
        end
        rst = 1'b1;
        #1;
        check("abort_rst_wr_en", rf_wr_en, 8'h00);
        check("abort_rst_busy", clr_busy, 1'b0);
        check("abort_rst_ready", req_ready, 3'b000);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_after_busy", clr_busy, 1'b0);
        check("abort_after_wr_en", rf_wr_en, 8'h00);
        check("abort_after_ready", req_ready, 3'b001);
        @(posedge clk);
        #1;
        req_valid = 3'b000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("abort_idle%0d_busy", k), clr_busy, 1'b0);
            check($sformatf("abort_idle%0d_wr_en", k), rf_wr_en, (k == 0) ? 8'h01 : 8'h00);
            @(posedge clk);
            #1;
        end

        // Randomized traffic against the reference model.
        do_reset();
        for (int c = 0; c < 400; c++) begin
            drive(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
                  ($urandom_range(0, 19) == 0));
            @(negedge clk);
            g = model_grant();
            check("rand_ready", req_ready, (g >= 0) ? (3'b001 << g) : 3'b000);
            if (exp_q.size() == 0) begin
                check("rand_queue_empty", 32'd0, 32'd1);
                e = '0;
            end else begin
                e = exp_q.pop_front();
            end
            check("rand_busy", clr_busy, e[QW-1]);
            check("rand_wr_en", rf_wr_en, e[DW +: NR]);
            if (e[DW +: NR] != '0) check("rand_wr_data", rf_wr_data, e[DW-1:0]);
            @(posedge clk);
            model_update(g);
            #1;
        end
        drive(3'b000, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0);

        // Six-register instance: index 6 is accepted but writes nothing.
        req_valid6 = 3'b001;
        req_addr6  = {3'd0, 3'd0, 3'd6};
        req_data6  = {16'h0, 16'h0, 16'h1234};
        @(negedge clk);
        check("oob_ready", req_ready6, 3'b001);
        @(posedge clk);
        #1;
        req_addr6 = {3'd0, 3'd0, 3'd5};
        req_data6 = {16'h0, 16'h0, 16'h5678};
        @(negedge clk);
        check("oob_wr_en", rf_wr_en6, 6'b000000);
        check("inrange_ready", req_ready6, 3'b001);
        @(posedge clk);
        #1;
        req_valid6 = 3'b000;
        @(negedge clk);
        check("inrange_wr_en", rf_wr_en6, 6'b100000);
        check("inrange_wr_data", rf_wr_data6, 16'h5678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
